// File: rtl/csr_access_unit_if.sv
// rtl/csr_access_unit_if.sv - execute-stage / CSR register-file signal bundle for csr_access_unit.
interface csr_access_unit_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_funct3;
  logic [11:0]     i_csr_addr;
  logic [4:0]      i_rs1_idx;
  logic [XLEN-1:0] i_rs1_data;
  logic [4:0]      i_rd_idx;
  logic            i_fp_busy;
  logic [11:0]     o_csr_addr;
  logic [1:0]      o_csr_op;
  logic            o_csr_write;
  logic [XLEN-1:0] o_csr_wdata;
  logic [XLEN-1:0] i_csr_rdata;
  logic            o_wb_valid;
  logic [4:0]      o_wb_rd;
  logic [XLEN-1:0] o_wb_data;
  logic            o_illegal;

  modport master (
    output i_valid, i_funct3, i_csr_addr, i_rs1_idx, i_rs1_data, i_rd_idx, i_fp_busy, i_csr_rdata,
    input  o_ready, o_csr_addr, o_csr_op, o_csr_write, o_csr_wdata, o_wb_valid, o_wb_rd, o_wb_data,
           o_illegal
  );

  modport slave (
    input  i_valid, i_funct3, i_csr_addr, i_rs1_idx, i_rs1_data, i_rd_idx, i_fp_busy, i_csr_rdata,
    output o_ready, o_csr_addr, o_csr_op, o_csr_write, o_csr_wdata, o_wb_valid, o_wb_rd, o_wb_data,
           o_illegal
  );
endinterface

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - Zicsr sequencer: IDLE->(DRAIN)->ACCESS->WB, one instruction in flight.
// Optional illegal-instruction detection under CSR_ILLEGAL_CHECK_EN.
module csr_access_unit #(
  parameter int XLEN      = 32,
  parameter int DRAIN_MAX = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  csr_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_ACCESS = 2'd2,
    S_WB     = 2'd3
  } state_e;

  localparam logic [7:0] DRAIN_LIM = 8'(DRAIN_MAX);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [11:0]     addr_q, addr_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [4:0]      rd_q, rd_d;
  logic            we_q, we_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic [1:0]      dec_op;
  logic [XLEN-1:0] dec_wdata;
  logic            dec_we;
  logic            dec_illegal;

  always_comb begin
    dec_op = 2'b00;
    case (bus.i_funct3[1:0])
      2'b10:   dec_op = 2'b01;
      2'b11:   dec_op = 2'b10;
      default: dec_op = 2'b00;
    endcase
  end

  assign dec_wdata = bus.i_funct3[2] ? {{(XLEN-5){1'b0}}, bus.i_rs1_idx} : bus.i_rs1_data;
  // Set/clear with x0 or uimm 0 is a pure read; funct3 x00 never writes.
  assign dec_we    = (bus.i_funct3[1:0] == 2'b00) ? 1'b0 :
                     (bus.i_funct3[1] ? (bus.i_rs1_idx != 5'd0) : 1'b1);

`ifdef CSR_ILLEGAL_CHECK_EN
  assign dec_illegal = (bus.i_funct3[1:0] == 2'b00) ||
                       !((bus.i_csr_addr == 12'h001) || (bus.i_csr_addr == 12'h002) ||
                         (bus.i_csr_addr == 12'h003));
`else
  assign dec_illegal = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    we_d      = we_q;
    illegal_d = illegal_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          addr_d    = bus.i_csr_addr;
          op_d      = dec_op;
          wdata_d   = dec_wdata;
          rd_d      = bus.i_rd_idx;
          we_d      = dec_we;
          illegal_d = dec_illegal;
          cnt_d     = 8'd0;
          if (dec_illegal)         state_d = S_WB;
          else if (bus.i_fp_busy)  state_d = S_DRAIN;
          else                     state_d = S_ACCESS;
        end
      end
      S_DRAIN: begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        // Give up waiting once this cycle completes DRAIN_MAX drain cycles.
        if (!bus.i_fp_busy || ((cnt_q + 8'd1) == DRAIN_LIM)) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        wb_data_d = bus.i_csr_rdata;
        state_d   = S_WB;
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= 12'd0;
      op_q      <= 2'b00;
      wdata_q   <= '0;
      rd_q      <= 5'd0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      illegal_q <= illegal_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.o_ready     = (state_q == S_IDLE);
  assign bus.o_csr_addr  = addr_q;
  assign bus.o_csr_wdata = wdata_q;
  assign bus.o_csr_op    = (state_q == S_ACCESS) ? op_q : 2'b00;
  assign bus.o_csr_write = (state_q == S_ACCESS) && we_q && !i_rst;
  assign bus.o_wb_valid  = (state_q == S_WB) && (rd_q != 5'd0) && !illegal_q && !i_rst;
  assign bus.o_wb_rd     = rd_q;
  assign bus.o_wb_data   = wb_data_q;
  assign bus.o_illegal   = (state_q == S_WB) && illegal_q && !i_rst;

endmodule

// File: tb/tb_csr_access_unit.sv
// tb/tb_csr_access_unit.sv - directed bench with per-cycle expectation schedule and CSR file model.
module tb_csr_access_unit;
  localparam int XLEN      = 32;
  localparam int DRAIN_MAX = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_access_unit_if #(.XLEN(XLEN)) bus();

  csr_access_unit #(.XLEN(XLEN), .DRAIN_MAX(DRAIN_MAX)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment register file: fflags(1), frm(2), fcsr(3); other addresses read 0.
  logic [31:0] env_csr [1:3];
  logic        env_load = 1'b1;
  assign bus.i_csr_rdata = (bus.o_csr_addr >= 12'd1 && bus.o_csr_addr <= 12'd3) ?
                           env_csr[bus.o_csr_addr[1:0]] : 32'h0;
  always @(posedge clk) begin
    if (env_load) begin
      env_csr[1] <= 32'h0A;
      env_csr[2] <= 32'h05;
      env_csr[3] <= 32'h12;
    end else if (bus.o_csr_write && bus.o_csr_addr >= 12'd1 && bus.o_csr_addr <= 12'd3) begin
      case (bus.o_csr_op)
        2'b00:   env_csr[bus.o_csr_addr[1:0]] <= bus.o_csr_wdata;
        2'b01:   env_csr[bus.o_csr_addr[1:0]] <= env_csr[bus.o_csr_addr[1:0]] | bus.o_csr_wdata;
        default: env_csr[bus.o_csr_addr[1:0]] <= env_csr[bus.o_csr_addr[1:0]] & ~bus.o_csr_wdata;
      endcase
    end
  end

  typedef struct {
    logic        ready;
    logic        write;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
  } exp_t;

  exp_t        sched [int];
  exp_t        idle_e;
  logic [31:0] mdl_csr [1:3];
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [4:0]  seen_rd = 5'd0;
  logic [31:0] seen_data = 32'h0;
  int          last_write_cyc = -1;

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (sched.exists(cyc)) e = sched[cyc];
      else e = idle_e;
      cmp("ready",    32'(bus.o_ready),     32'(e.ready));
      cmp("write",    32'(bus.o_csr_write), 32'(e.write));
      cmp("op",       32'(bus.o_csr_op),    32'(e.op));
      cmp("addr",     32'(bus.o_csr_addr),  32'(e.addr));
      cmp("wdata",    bus.o_csr_wdata,      e.wdata);
      cmp("wb_valid", 32'(bus.o_wb_valid),  32'(e.wb_valid));
      cmp("wb_rd",    32'(bus.o_wb_rd),     32'(e.wb_rd));
      cmp("wb_data",  bus.o_wb_data,        e.wb_data);
      cmp("illegal",  32'(bus.o_illegal),   32'(e.illegal));
      if (bus.o_wb_valid) begin
        seen_rd   = bus.o_wb_rd;
        seen_data = bus.o_wb_data;
      end
      if (bus.o_csr_write) last_write_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction at the current cycle, builds the expected per-cycle outputs from
  // the instruction semantics, then drives it until the unit is idle again.
  task automatic run_instr(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] idx,
                           input logic [31:0] data, input logic [4:0] rd, input int busy_n,
                           input bit rst_in_access);
    int t, d, a, last;
    logic [1:0]  op;
    logic [31:0] wd, old;
    bit we, ill;
    exp_t e, ea, ew;
    t = cyc;
    op = (f3[1:0] == 2'b10) ? 2'b01 : (f3[1:0] == 2'b11) ? 2'b10 : 2'b00;
    wd = f3[2] ? {27'b0, idx} : data;
    we = (f3[1:0] == 2'b00) ? 1'b0 : (f3[1] ? (idx != 5'd0) : 1'b1);
    ill = 1'b0;
`ifdef CSR_ILLEGAL_CHECK_EN
    ill = (f3[1:0] == 2'b00) || !(addr inside {12'h001, 12'h002, 12'h003});
`endif
    old = (addr >= 12'd1 && addr <= 12'd3) ? mdl_csr[addr[1:0]] : 32'h0;
    d = (busy_n > DRAIN_MAX) ? DRAIN_MAX : busy_n;
    a = -1;
    sched[t] = idle_e;
    e = idle_e;
    e.ready = 1'b0;
    e.addr  = addr;
    e.wdata = wd;
    e.wb_rd = rd;
    if (ill) begin
      e.illegal = 1'b1;
      sched[t+1] = e;
      last = t + 1;
    end else begin
      for (int i = 1; i <= d; i++) sched[t+i] = e;
      a = t + 1 + d;
      ea = e;
      ea.write = we && !rst_in_access;
      ea.op    = op;
      sched[a] = ea;
      if (rst_in_access) begin
        last = a;
      end else begin
        ew = e;
        ew.wb_valid = (rd != 5'd0);
        ew.wb_data  = old;
        sched[a+1] = ew;
        last = a + 1;
      end
    end
    if (rst_in_access) begin
      idle_e.addr = 12'h0; idle_e.wdata = 32'h0; idle_e.wb_rd = 5'd0; idle_e.wb_data = 32'h0;
    end else begin
      idle_e.addr = addr; idle_e.wdata = wd; idle_e.wb_rd = rd;
      if (!ill) idle_e.wb_data = old;
      if (we && !ill && addr >= 12'd1 && addr <= 12'd3) begin
        case (op)
          2'b00:   mdl_csr[addr[1:0]] = wd;
          2'b01:   mdl_csr[addr[1:0]] = old | wd;
          default: mdl_csr[addr[1:0]] = old & ~wd;
        endcase
      end
    end

    bus.i_valid    = 1'b1;
    bus.i_funct3   = f3;
    bus.i_csr_addr = addr;
    bus.i_rs1_idx  = idx;
    bus.i_rs1_data = data;
    bus.i_rd_idx   = rd;
    bus.i_fp_busy  = (busy_n > 0);
    while (cyc <= last) begin
      step();
      bus.i_valid   = 1'b0;
      bus.i_fp_busy = ((cyc - t) < busy_n);
      rst = (rst_in_access && cyc == a);
    end
    bus.i_fp_busy = 1'b0;
  endtask

  initial begin
    int t0;
    bus.i_valid = 1'b0; bus.i_funct3 = 3'b0; bus.i_csr_addr = 12'h0; bus.i_rs1_idx = 5'd0;
    bus.i_rs1_data = 32'h0; bus.i_rd_idx = 5'd0; bus.i_fp_busy = 1'b0;
    idle_e.ready = 1'b1; idle_e.write = 1'b0; idle_e.op = 2'b00; idle_e.addr = 12'h0;
    idle_e.wdata = 32'h0; idle_e.wb_valid = 1'b0; idle_e.wb_rd = 5'd0; idle_e.wb_data = 32'h0;
    idle_e.illegal = 1'b0;
    mdl_csr[1] = 32'h0A; mdl_csr[2] = 32'h05; mdl_csr[3] = 32'h12;
    repeat (3) step();
    rst = 1'b0;
    env_load = 1'b0;

    cmp("reset_ready",   32'(bus.o_ready), 32'd1);
    cmp("reset_write",   32'(bus.o_csr_write), 32'd0);
    cmp("reset_addr",    32'(bus.o_csr_addr), 32'd0);
    cmp("reset_wb_data", bus.o_wb_data, 32'd0);
    step();
    chk_en = 1'b1;

    t0 = cyc;
    run_instr(3'b001, 12'h003, 5'd1, 32'hA5, 5'd5, 0, 1'b0);
    cmp("csrrw_write_cycle", 32'(last_write_cyc), 32'(t0 + 1));
    cmp("csrrw_wb_rd", 32'(seen_rd), 32'd5);
    cmp("csrrw_wb_old", seen_data, 32'h12);
    cmp("csrrw_fcsr_new", env_csr[3], 32'hA5);

    run_instr(3'b110, 12'h001, 5'd0, 32'hFFFF_FFFF, 5'd6, 0, 1'b0);
    cmp("csrrsi0_wb_old", seen_data, 32'h0A);
    cmp("csrrsi0_fflags_kept", env_csr[1], 32'h0A);

    t0 = cyc;
    run_instr(3'b111, 12'h002, 5'd3, 32'h0, 5'd7, 4, 1'b0);
    cmp("csrrci_drain_write_cycle", 32'(last_write_cyc), 32'(t0 + 5));
    cmp("csrrci_wb_old", seen_data, 32'h05);
    cmp("csrrci_frm_new", env_csr[2], 32'h04);

    run_instr(3'b010, 12'h001, 5'd2, 32'h11, 5'd0, 0, 1'b0);
    cmp("csrrs_rd0_fflags_new", env_csr[1], 32'h1B);
    cmp("csrrs_rd0_no_wb", 32'(seen_rd), 32'd7);

    t0 = cyc;
    run_instr(3'b011, 12'h003, 5'd3, 32'h0F, 5'd8, 300, 1'b0);
    cmp("stuck_busy_write_cycle", 32'(last_write_cyc), 32'(t0 + 256));
    cmp("stuck_busy_wb_old", seen_data, 32'hA5);
    cmp("stuck_busy_fcsr_new", env_csr[3], 32'hA0);

    run_instr(3'b001, 12'h003, 5'd4, 32'hFF, 5'd9, 0, 1'b1);
    cmp("rst_access_fcsr_kept", env_csr[3], 32'hA0);
    cmp("rst_access_no_wb", 32'(seen_rd), 32'd8);

    run_instr(3'b001, 12'h300, 5'd1, 32'h1, 5'd10, 0, 1'b0);
`ifdef CSR_ILLEGAL_CHECK_EN
    cmp("illegal_addr_no_wb", 32'(seen_rd), 32'd8);
`else
    cmp("unsupported_addr_wb_rd", 32'(seen_rd), 32'd10);
    cmp("unsupported_addr_wb_zero", seen_data, 32'h0);
`endif

    run_instr(3'b000, 12'h001, 5'd5, 32'h3, 5'd11, 0, 1'b0);
    cmp("funct3_000_fflags_kept", env_csr[1], 32'h1B);

    run_instr(3'b101, 12'h002, 5'd31, 32'h0, 5'd12, 0, 1'b0);
    cmp("csrrwi_wb_old", seen_data, 32'h04);
    cmp("csrrwi_frm_new", env_csr[2], 32'h1F);

    run_instr(3'b001, 12'h002, 5'd6, 32'h2, 5'd0, 0, 1'b0);
    cmp("csrrw_rd0_frm_new", env_csr[2], 32'h02);
    cmp("csrrw_rd0_no_wb", 32'(seen_rd), 32'd12);

    repeat (2) step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
